// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  // Default byte width, matching the downstream uart_tx data port.
  localparam int UART_DAT_WIDTH = 8;

  // Arbiter control states: choose an owner, run the bus write, report completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request found when
// searching from i_ptr upward, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [PW-1:0]    o_idx,
  output logic             o_valid
);

  logic [PW:0]    w_sum  [N_REQ];
  logic [PW-1:0]  w_cand [N_REQ];
  logic [N_REQ-1:0] w_hit;

  // Candidate index for each search offset; i_ptr < N_REQ, so one
  // conditional subtract is enough to wrap.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign w_sum[gi]  = {1'b0, i_ptr} + (PW+1)'(gi);
      assign w_cand[gi] = (w_sum[gi] >= (PW+1)'(N_REQ)) ?
                          PW'(w_sum[gi] - (PW+1)'(N_REQ)) :
                          w_sum[gi][PW-1:0];
      assign w_hit[gi]  = i_req[w_cand[gi]];
    end
  endgenerate

  // Priority select: walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_valid  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[i];
      end
    end
    if (o_valid) begin
      o_onehot[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte
// producers. Each granted byte becomes one Wishbone classic write; an
// optional lock keeps ownership for up to MAX_LOCK consecutive bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DAT_WIDTH = UART_DAT_WIDTH,
  parameter int MAX_LOCK  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N_REQ-1:0]                req_i,
  input  logic [N_REQ-1:0]                lock_i,
  input  logic [N_REQ-1:0][DAT_WIDTH-1:0] dat_i,
  output logic [N_REQ-1:0]                grant_o,
  output logic [N_REQ-1:0]                done_o,
  output logic                            cyc_o,
  output logic                            stb_o,
  output logic                            we_o,
  output logic [DAT_WIDTH-1:0]            dat_o,
  input  logic                            ack_i
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LCW = $clog2(MAX_LOCK) + 1;

  // Registered state
  arb_state_t         r_state;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_done;
  logic               r_cyc;
  logic [DAT_WIDTH-1:0] r_dat;
  logic [PW-1:0]      r_owner;
  logic [PW-1:0]      r_ptr;
  logic [LCW-1:0]     r_lock_cnt;
  logic               r_locked;

  // Next-state values
  arb_state_t         w_state_next;
  logic [N_REQ-1:0]   w_grant_next;
  logic [N_REQ-1:0]   w_done_next;
  logic               w_cyc_next;
  logic [DAT_WIDTH-1:0] w_dat_next;
  logic [PW-1:0]      w_owner_next;
  logic [PW-1:0]      w_ptr_next;
  logic [LCW-1:0]     w_lock_cnt_next;
  logic               w_locked_next;

  // Arbiter interface
  logic [PW-1:0]      w_arb_ptr;
  logic [N_REQ-1:0]   w_win_onehot;
  logic [PW-1:0]      w_win_idx;
  logic               w_win_valid;
  logic [PW-1:0]      w_owner_inc;
  logic [N_REQ-1:0]   w_owner_onehot;

  // Successor of an index, wrapping at N_REQ-1.
  function automatic logic [PW-1:0] inc_idx(input logic [PW-1:0] idx);
    return (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign w_owner_inc    = inc_idx(r_owner);
  assign w_owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

  // A held lock whose owner has gone away hands priority to the next index
  // in the same cycle, so the search starts just past the old owner.
  assign w_arb_ptr = r_locked ? w_owner_inc : r_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .i_req    (req_i),
    .i_ptr    (w_arb_ptr),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  // State register: every output comes straight from a flop here.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_done     <= '0;
      r_cyc      <= 1'b0;
      r_dat      <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_done     <= w_done_next;
      r_cyc      <= w_cyc_next;
      r_dat      <= w_dat_next;
      r_owner    <= w_owner_next;
      r_ptr      <= w_ptr_next;
      r_lock_cnt <= w_lock_cnt_next;
      r_locked   <= w_locked_next;
    end
  end

  // Next-state and registered-output logic for the IDLE/BUS/DONE sequence.
  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_done_next     = '0;
    w_cyc_next      = r_cyc;
    w_dat_next      = r_dat;
    w_owner_next    = r_owner;
    w_ptr_next      = r_ptr;
    w_lock_cnt_next = r_lock_cnt;
    w_locked_next   = r_locked;

    case (r_state)
      IDLE: begin
        if (r_locked && req_i[r_owner]) begin
          // Locked owner keeps the transmitter regardless of other requests.
          w_state_next = BUS;
          w_cyc_next   = 1'b1;
          w_grant_next = w_owner_onehot;
          w_dat_next   = dat_i[r_owner];
        end else begin
          if (r_locked) begin
            w_locked_next   = 1'b0;
            w_lock_cnt_next = '0;
            w_ptr_next      = w_owner_inc;
          end
          if (w_win_valid) begin
            w_state_next = BUS;
            w_cyc_next   = 1'b1;
            w_owner_next = w_win_idx;
            w_grant_next = w_win_onehot;
            w_dat_next   = dat_i[w_win_idx];
          end
        end
      end

      BUS: begin
        if (ack_i) begin
          w_state_next = DONE;
          w_cyc_next   = 1'b0;
          w_done_next  = r_grant;
        end
      end

      DONE: begin
        w_state_next = IDLE;
        w_grant_next = '0;
        if (lock_i[r_owner] && (r_lock_cnt < LCW'(MAX_LOCK - 1))) begin
          w_locked_next   = 1'b1;
          w_lock_cnt_next = r_lock_cnt + 1'b1;
        end else begin
          w_locked_next   = 1'b0;
          w_lock_cnt_next = '0;
          w_ptr_next      = w_owner_inc;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_cyc_next   = 1'b0;
        w_grant_next = '0;
      end
    endcase
  end

  assign grant_o = r_grant;
  assign done_o  = r_done;
  assign cyc_o   = r_cyc;
  assign stb_o   = r_cyc;
  assign we_o    = r_cyc;
  assign dat_o   = r_dat;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table of byte transactions plus
// hand-written sequences, with a scoreboard of expected owner/data per write.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int ML = 3;

  logic                 clk_i;
  logic                 rst_ni;
  logic [N-1:0]         req_i;
  logic [N-1:0]         lock_i;
  logic [N-1:0][DW-1:0] dat_i;
  logic [N-1:0]         grant_o;
  logic [N-1:0]         done_o;
  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [DW-1:0]        dat_o;
  logic                 ack_i;

  logic stub_ack;
  logic force_ack;
  int   ack_dly;
  int   stub_cnt;

  assign ack_i = stub_ack | force_ack;

  typedef struct {
    logic [1:0]    owner;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] lock;
    int           dly;
    int           owner;
  } vec_t;

  exp_t sb[$];
  exp_t m_e;
  vec_t tbl[16];

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_arbiter #(
    .N_REQ     (N),
    .DAT_WIDTH (DW),
    .MAX_LOCK  (ML)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .lock_i  (lock_i),
    .dat_i   (dat_i),
    .grant_o (grant_o),
    .done_o  (done_o),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .we_o    (we_o),
    .dat_o   (dat_o),
    .ack_i   (ack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Wishbone slave stub: acks once cyc/stb has been seen for ack_dly cycles.
  initial begin
    stub_ack = 1'b0;
    stub_cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (stub_ack) begin
        stub_ack = 1'b0;
        stub_cnt = 0;
      end else if (cyc_o && stb_o) begin
        if (stub_cnt >= ack_dly) stub_ack = 1'b1;
        else stub_cnt++;
      end else begin
        stub_cnt = 0;
      end
    end
  end

  // Monitor: bus cycles and done pulses compared against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (done_o != '0) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: done_o=%b with nothing outstanding", done_o);
        end else begin
          m_e = sb.pop_front();
          check("done_o",     32'(done_o),  32'(1) << m_e.owner);
          check("done_grant", 32'(grant_o), 32'(1) << m_e.owner);
          check("done_dat",   32'(dat_o),   32'(m_e.data));
          check("done_cyc",   32'(cyc_o),   32'(0));
          $display("txn owner=%0d data=%02h", m_e.owner, m_e.data);
        end
      end else if (cyc_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL bus_unexpected: cyc_o=1 grant_o=%b with nothing outstanding", grant_o);
        end else begin
          check("bus_grant", 32'(grant_o), 32'(1) << sb[0].owner);
          check("bus_dat",   32'(dat_o),   32'(sb[0].data));
          check("bus_stbwe", 32'({stb_o, we_o}), 32'(2'b11));
        end
      end
    end
  end

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk_i);
      if (done_o != '0) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s: no done_o within 100 cycles", name);
    end
  endtask

  // One byte: drive request/lock/data, expect the given owner, wait for done.
  task automatic run_txn(input logic [N-1:0] req, input logic [N-1:0] lock,
                         input int dly, input int owner, input string name);
    exp_t e;
    ack_dly = dly;
    lock_i  = lock;
    for (int k = 0; k < N; k++) dat_i[k] = 8'($urandom_range(0, 255));
    req_i   = req;
    e.owner = 2'(owner);
    e.data  = dat_i[owner];
    sb.push_back(e);
    wait_done(name);
    @(posedge clk_i);
    #1;
    req_i  = '0;
    lock_i = '0;
  endtask

  initial begin
    exp_t e;
    rst_ni    = 1'b0;
    req_i     = '0;
    lock_i    = '0;
    dat_i     = '0;
    force_ack = 1'b0;
    ack_dly   = 0;

    // fairness (ptr starts at 1 after the single request)
    tbl[0]  = '{4'b1111, 4'b0000, 1, 1};
    tbl[1]  = '{4'b1111, 4'b0000, 0, 2};
    tbl[2]  = '{4'b1111, 4'b0000, 2, 3};
    tbl[3]  = '{4'b1111, 4'b0000, 3, 0};
    tbl[4]  = '{4'b1111, 4'b0000, 1, 1};
    // lock bound with MAX_LOCK=3
    tbl[5]  = '{4'b0011, 4'b0001, 0, 0};
    tbl[6]  = '{4'b0011, 4'b0001, 1, 0};
    tbl[7]  = '{4'b0011, 4'b0001, 0, 0};
    tbl[8]  = '{4'b0011, 4'b0001, 2, 1};
    tbl[9]  = '{4'b0011, 4'b0001, 0, 0};
    tbl[10] = '{4'b0011, 4'b0001, 1, 0};
    tbl[11] = '{4'b0011, 4'b0001, 0, 0};
    tbl[12] = '{4'b0011, 4'b0001, 2, 1};
    // lock release: 2 locked, then drops its request
    tbl[13] = '{4'b1100, 4'b0100, 1, 2};
    tbl[14] = '{4'b1000, 4'b0000, 0, 3};
    tbl[15] = '{4'b0110, 4'b0000, 1, 1};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_grant", 32'(grant_o), 32'(0));
    check("rst_done",  32'(done_o),  32'(0));
    check("rst_cyc",   32'({cyc_o, stb_o, we_o}), 32'(0));
    check("rst_dat",   32'(dat_o),   32'(0));
    rst_ni = 1'b1;

    // Single request with ack after 5
    ack_dly  = 5;
    dat_i[0] = 8'h41;
    req_i    = 4'b0001;
    e.owner  = 2'd0;
    e.data   = 8'h41;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    check("single_cyc",   32'(cyc_o),   32'(1));
    check("single_grant", 32'(grant_o), 32'(4'b0001));
    check("single_dat",   32'(dat_o),   32'(8'h41));
    wait_done("single_done");
    req_i = '0;
    @(negedge clk_i);
    check("single_gap_cyc",  32'(cyc_o),  32'(0));
    check("single_gap_done", 32'(done_o), 32'(0));
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 16; i++) begin
      run_txn(tbl[i].req, tbl[i].lock, tbl[i].dly, tbl[i].owner, $sformatf("tbl%0d", i));
    end

    // Withdrawal and data stability: 1 and 3 request, 3 wins, 1 withdraws
    ack_dly = 4;
    for (int k = 0; k < N; k++) dat_i[k] = 8'($urandom_range(0, 255));
    req_i   = 4'b1010;
    e.owner = 2'd3;
    e.data  = dat_i[3];
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    check("wd_grant", 32'(grant_o), 32'(4'b1000));
    dat_i[3] = ~dat_i[3];
    dat_i[1] = ~dat_i[1];
    req_i    = 4'b1000;
    wait_done("wd_done");
    @(posedge clk_i);
    #1;
    req_i = '0;
    run_txn(4'b0100, 4'b0000, 1, 2, "after_withdraw");

    // Ack outside BUS must be ignored
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("idle_ack_cyc",  32'(cyc_o),  32'(0));
      check("idle_ack_done", 32'(done_o), 32'(0));
    end
    @(posedge clk_i);
    #1;
    force_ack = 1'b0;

    // Set ptr to 2, then abort a write from requester 2 with reset
    run_txn(4'b0010, 4'b0000, 0, 1, "pre_reset");
    ack_dly = 20;
    for (int k = 0; k < N; k++) dat_i[k] = 8'($urandom_range(0, 255));
    req_i   = 4'b0100;
    e.owner = 2'd2;
    e.data  = dat_i[2];
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    check("abort_grant", 32'(grant_o), 32'(4'b0100));
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    req_i  = '0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check("abort_cyc",   32'(cyc_o),   32'(0));
    check("abort_grant_clr", 32'(grant_o), 32'(0));
    check("abort_done",  32'(done_o),  32'(0));
    sb.delete();
    repeat (3) begin
      @(negedge clk_i);
      check("abort_no_done", 32'(done_o), 32'(0));
    end
    @(posedge clk_i);
    #1;
    run_txn(4'b0110, 4'b0000, 2, 1, "post_reset_ptr0");

    repeat (3) @(posedge clk_i);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL sb_leftover: %0d expected writes never completed", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
